univ_rotate_ctrl: RTL and testbench
===================================

# univ_rotate_ctrl

Command-driven sequencer for a universal rotate register. It accepts one rotate command per valid/ready handshake and drives the register's 2-bit control and load data. The command can load a value and then rotate it left or right by a programmed number of single-bit steps. When the sequence finishes, the block captures the register output and reports it with a one-cycle done pulse. It sits between a requester (software-visible regs or a higher FSM) and the rotate register, which shares the same clock.

## Interface
- DW, 4, data width of the controlled rotate register
- AW, 4, width of the rotate-amount field (0 .. 2^AW-1 steps)

- clk  input  1  clock, rising edge
- async_rst_n  input  1  asynchronous reset, active low
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller idle, command accepted on cmd_valid&&cmd_ready at posedge
- cmd_load  input  1  1: load cmd_data before rotating; 0: rotate current register contents
- cmd_dir  input  1  0: rotate left (q<={q[DW-2:0],q[DW-1]}); 1: rotate right (q<={q[0],q[DW-1:1]})
- cmd_amt  input  AW  number of single-bit rotate steps
- cmd_data  input  DW  load value
- reg_ctrl  output  2  to register: 00 load, 10 rotate left, 01 rotate right, 11 hold
- reg_data  output  DW  to register data input
- reg_q  input  DW  register output
- busy  output  1  high when not IDLE
- done  output  1  one-cycle pulse, result valid
- result  output  DW  reg_q captured at end of sequence, held until next done

## Operation
- FSM states: IDLE, LOAD, ROT, FIN. Moore outputs decoded from the state register. Step counter is AW bits.
- IDLE: reg_ctrl=11, cmd_ready=1, busy=0.
  - On handshake, capture load/dir/amt/data.
  - Next state is LOAD if cmd_load=1; else ROT if amt!=0; else FIN.
- LOAD: reg_ctrl=00, reg_data=captured data. Next state is ROT if amt!=0, else FIN.
- ROT: reg_ctrl=10 (dir=0) or 01 (dir=1).
  - Counter loaded with amt on entry and decremented each edge in ROT.
  - Leave to FIN on the edge where counter==1, so exactly amt rotate edges occur.
- FIN: reg_ctrl=11. On the next edge: result<=reg_q, done<=1, state<=IDLE.
- done is registered and is high in the first IDLE cycle only.
- No modulo reduction of amt: amt=DW returns the original value and costs DW cycles.
- reg_data holds the last loaded value outside LOAD. It is 0 after reset.
- cmd_* inputs are ignored unless a handshake occurs. cmd_valid while busy is stalled, not dropped.

## Timing
- Reset (async assert): state=IDLE, reg_ctrl=11, reg_data=0, result=0, done=0, counter=0, busy=0, cmd_ready=1.
- Reset release is synchronous to clk.
- Accept at edge E0, load=1, amt=N>0:
  - LOAD cycle; register loads at E1.
  - ROT for N cycles, edges E2..E(N+1).
  - FIN cycle.
  - At E(N+2): done=1, result valid, cmd_ready=1.
  - Total latency is N+2 edges.
- load=0, amt=N>0: done at E(N+1).
- load=1, amt=0: done at E2.
- load=0, amt=0: done at E1, result = current reg_q.
- Back-to-back: a new handshake is allowed in the cycle done=1, so throughput is one command per latency+1 cycles.
- Reset mid-sequence (any state): immediate return to IDLE and reg_ctrl=11. The command is discarded, no done pulse, and result is cleared to 0.

## Test plan
- Reset: async_rst_n=0 asynchronously mid-cycle -> reg_ctrl=11, result=0, done=0, cmd_ready=1 with no clock edge needed.
- Load+left: cmd_load=1, data=4'b1011, dir=0, amt=1 -> reg_ctrl sequence 00,10,11; done 3 edges after accept; result=4'b0111.
- Left by 3, no load: register preloaded 4'b1000, cmd_load=0, dir=0, amt=3 -> q steps 0001,0010,0100; done at E4; result=4'b0100.
- Right: load 4'b0110, dir=1, amt=2 -> q 0011 then 1001; result=4'b1001.
- Full wrap and amt=0:
  - load 4'b1001, dir=0, amt=4 -> result=4'b1001, done at E6.
  - cmd_load=0, amt=0 -> done at E1, result = current q, reg_ctrl stays 11.
- Stall, back-to-back and reset abort:
  - Hold cmd_valid during busy -> cmd_ready=0, and the command is taken in the done cycle.
  - Assert reset during ROT with amt=5 -> no done pulse, reg_ctrl=11 immediately.
  - A subsequent command completes normally.

Source files
------------

// File: rtl/univ_rotate_ctrl.sv
// univ_rotate_ctrl
// ----------------
// Command sequencer for a universal rotate register that shares this clock.
// A command is accepted with a valid/ready handshake. It can optionally load a
// value into the register. It then rotates the register left or right by
// cmd_amt single-bit steps. Finally it captures the register output into
// result and pulses done for one cycle.
//
// Ports
//   clk          rising-edge clock
//   async_rst_n  asynchronous reset, active low
//   cmd_valid    command present
//   cmd_ready    controller idle; a command is taken on cmd_valid && cmd_ready
//   cmd_load     1: load cmd_data before rotating, 0: rotate current contents
//   cmd_dir      0: rotate left, 1: rotate right
//   cmd_amt      number of single-bit rotate steps (no modulo reduction)
//   cmd_data     value to load
//   reg_ctrl     register control: 00 load, 10 rotate left, 01 rotate right,
//                11 hold
//   reg_data     register load data; holds the last loaded value
//   reg_q        register output
//   busy         high while a command is in progress
//   done         one-cycle pulse, result valid
//   result       reg_q captured at the end of the sequence
module univ_rotate_ctrl #(
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          async_rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_load,
  input  logic          cmd_dir,
  input  logic [AW-1:0] cmd_amt,
  input  logic [DW-1:0] cmd_data,
  output logic [1:0]    reg_ctrl,
  output logic [DW-1:0] reg_data,
  input  logic [DW-1:0] reg_q,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ROT  = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam logic [1:0] CTRL_LOAD = 2'b00;
  localparam logic [1:0] CTRL_ROTL = 2'b10;
  localparam logic [1:0] CTRL_ROTR = 2'b01;
  localparam logic [1:0] CTRL_HOLD = 2'b11;

  localparam logic [AW-1:0] AMT_ZERO = '0;
  localparam logic [AW-1:0] AMT_ONE  = AW'(1);

  state_e        state_q, state_d;
  logic          dir_q, dir_d;
  logic [AW-1:0] amt_q, amt_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] result_q, result_d;
  logic          done_q, done_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          accept;

  // A command is only looked at while idle; while busy it simply waits on
  // cmd_valid until the controller returns to IDLE.
  assign accept = (state_q == IDLE) && cmd_valid;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    amt_d    = amt_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          dir_d = cmd_dir;
          amt_d = cmd_amt;
          if (cmd_load) begin
            // reg_data only changes on a load command, so outside LOAD it
            // keeps presenting the last loaded value.
            data_d  = cmd_data;
            state_d = LOAD;
          end else if (cmd_amt != AMT_ZERO) begin
            cnt_d   = cmd_amt;
            state_d = ROT;
          end else begin
            state_d = FIN;
          end
        end
      end

      LOAD: begin
        if (amt_q != AMT_ZERO) begin
          cnt_d   = amt_q;
          state_d = ROT;
        end else begin
          state_d = FIN;
        end
      end

      ROT: begin
        // Counter is preloaded with amt on entry; leaving on the edge where it
        // reads 1 gives exactly amt rotate edges.
        cnt_d = cnt_q - AMT_ONE;
        if (cnt_q == AMT_ONE) begin
          state_d = FIN;
        end
      end

      FIN: begin
        // The register holds during FIN, so reg_q is stable for capture.
        result_d = reg_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Moore outputs are decoded from the next state and registered, so they
    // line up with the state register without combinational glitches.
    case (state_d)
      LOAD:    ctrl_d = CTRL_LOAD;
      ROT:     ctrl_d = dir_d ? CTRL_ROTR : CTRL_ROTL;
      default: ctrl_d = CTRL_HOLD;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      amt_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      ctrl_q   <= CTRL_HOLD;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      amt_q    <= amt_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      result_q <= result_d;
      done_q   <= done_d;
      ctrl_q   <= ctrl_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign reg_ctrl  = ctrl_q;
  assign reg_data  = data_q;

endmodule

// File: tb/tb_univ_rotate_ctrl.sv
// Directed bench for univ_rotate_ctrl with a behavioural rotate register
// attached to the control outputs and a scoreboard of expected results.
module tb_univ_rotate_ctrl;

  localparam int DW = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          async_rst_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_load = 1'b0;
  logic          cmd_dir = 1'b0;
  logic [AW-1:0] cmd_amt = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [1:0]    reg_ctrl;
  logic [DW-1:0] reg_data;
  logic [DW-1:0] mq = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;

  typedef struct {
    logic [DW-1:0] res;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad = 0;
  int            viol = 0;
  logic [1:0]    ctrl_log[48];
  logic [DW-1:0] q_log[48];

  univ_rotate_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .async_rst_n(async_rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_load   (cmd_load),
    .cmd_dir    (cmd_dir),
    .cmd_amt    (cmd_amt),
    .cmd_data   (cmd_data),
    .reg_ctrl   (reg_ctrl),
    .reg_data   (reg_data),
    .reg_q      (mq),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  always #5 clk = ~clk;

  // Universal rotate register driven by the controller.
  always @(posedge clk) begin
    case (reg_ctrl)
      2'b00:   mq <= reg_data;
      2'b10:   mq <= {mq[DW-2:0], mq[DW-1]};
      2'b01:   mq <= {mq[0], mq[DW-1:1]};
      default: mq <= mq;
    endcase
  end

  function automatic logic [DW-1:0] rot(input logic [DW-1:0] v, input bit dr, input int n);
    logic [DW-1:0] t;
    t = v;
    for (int i = 0; i < n; i++) begin
      if (dr) t = {t[0], t[DW-1:1]};
      else    t = {t[DW-2:0], t[DW-1]};
    end
    return t;
  endfunction

  function automatic int exp_lat(input bit ld, input int amt);
    int l;
    l = (amt == 0) ? 1 : amt + 1;
    if (ld) l = l + 1;
    return l;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present a command, wait (bounded) for ready, push its expectation and
  // return one time step after the accepting edge E0.
  task automatic issue(input bit ld, input bit dr, input int amt, input logic [DW-1:0] d);
    int   n;
    exp_t e;
    n = 0;
    cmd_load  = ld;
    cmd_dir   = dr;
    cmd_amt   = amt[AW-1:0];
    cmd_data  = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("accept_ready", {31'd0, cmd_ready}, 32'd1);
    e.res = rot(ld ? d : mq, dr, amt);
    e.lat = exp_lat(ld, amt);
    sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid   = 1'b0;
    ctrl_log[0] = reg_ctrl;
    q_log[0]    = mq;
  endtask

  // Count edges after E0 until done, then compare against the scoreboard.
  task automatic wait_done(input string tag);
    int   n;
    bit   got;
    exp_t e;
    n   = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk); #1; n++;
      ctrl_log[n] = reg_ctrl;
      q_log[n]    = mq;
      if (busy && cmd_ready) viol++;
      if (done) got = 1'b1;
    end
    check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_latency"}, n, e.lat);
      check({tag, "_result"}, {28'd0, result}, {28'd0, e.res});
    end else begin
      check({tag, "_scoreboard_entry"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   dcount;
    exp_t e;

    // Reset asserted mid-cycle with no clock edge yet.
    #2 async_rst_n = 1'b0;
    #1;
    check("rst_ctrl", {30'd0, reg_ctrl}, 32'h3);
    check("rst_result", {28'd0, result}, 32'h0);
    check("rst_done", {31'd0, done}, 32'h0);
    check("rst_ready", {31'd0, cmd_ready}, 32'h1);
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_data", {28'd0, reg_data}, 32'h0);
    @(negedge clk); @(negedge clk);
    async_rst_n = 1'b1;
    @(posedge clk); #1;

    // Load + rotate left by one.
    issue(1'b1, 1'b0, 1, 4'b1011);
    check("ll_data", {28'd0, reg_data}, 32'hB);
    wait_done("load_left1");
    check("ll_ctrl0", {30'd0, ctrl_log[0]}, 32'h0);
    check("ll_ctrl1", {30'd0, ctrl_log[1]}, 32'h2);
    check("ll_ctrl2", {30'd0, ctrl_log[2]}, 32'h3);
    check("ll_res_const", {28'd0, result}, 32'h7);

    // Preload 1000, then rotate left by 3 without load.
    issue(1'b1, 1'b0, 0, 4'b1000);
    wait_done("preload");
    issue(1'b0, 1'b0, 3, 4'b1111);
    wait_done("left3");
    check("l3_q1", {28'd0, q_log[1]}, 32'h1);
    check("l3_q2", {28'd0, q_log[2]}, 32'h2);
    check("l3_q3", {28'd0, q_log[3]}, 32'h4);
    check("l3_data_held", {28'd0, reg_data}, 32'h8);

    // Rotate right by 2.
    issue(1'b1, 1'b1, 2, 4'b0110);
    wait_done("right2");
    check("r2_q2", {28'd0, q_log[2]}, 32'h3);
    check("r2_q3", {28'd0, q_log[3]}, 32'h9);
    check("r2_res_const", {28'd0, result}, 32'h9);

    // Full wrap: amt equal to the width.
    issue(1'b1, 1'b0, 4, 4'b1001);
    wait_done("wrap4");
    check("wrap_res_const", {28'd0, result}, 32'h9);

    // No load, amt=0: captures current contents, control stays at hold.
    issue(1'b0, 1'b1, 0, 4'b0000);
    check("z_ctrl0", {30'd0, reg_ctrl}, 32'h3);
    wait_done("noload_amt0");

    // Stall: second command held on cmd_valid while busy.
    viol = 0;
    issue(1'b1, 1'b0, 2, 4'b0011);
    cmd_load  = 1'b0;
    cmd_dir   = 1'b1;
    cmd_amt   = 4'd1;
    cmd_data  = 4'b1111;
    cmd_valid = 1'b1;
    wait_done("stall_A");
    check("stall_ready_low_while_busy", viol, 0);
    check("stall_ready_in_done", {31'd0, cmd_ready}, 32'h1);
    e.res = rot(4'b1100, 1'b1, 1);
    e.lat = exp_lat(1'b0, 1);
    sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("stall_B_taken", {31'd0, busy}, 32'h1);
    wait_done("stall_B");

    // Reset during ROT.
    issue(1'b1, 1'b0, 5, 4'b0101);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_in_rot", {30'd0, reg_ctrl}, 32'h2);
    #2 async_rst_n = 1'b0;
    #1;
    check("abort_ctrl", {30'd0, reg_ctrl}, 32'h3);
    check("abort_busy", {31'd0, busy}, 32'h0);
    check("abort_ready", {31'd0, cmd_ready}, 32'h1);
    check("abort_result", {28'd0, result}, 32'h0);
    void'(sb.pop_front());
    @(negedge clk);
    async_rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("abort_no_done", dcount, 0);

    // Subsequent command completes normally.
    issue(1'b0, 1'b1, 3, 4'b0000);
    wait_done("after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
